// File: rtl/mem_axi_lite_master_if.sv
// AXI4-Lite bus bundle between the memory-stage master and its slave.
// Signal names follow the AXI channel names with an m_ prefix.
interface mem_axi_lite_master_if;

    // Write address channel
    logic [31:0] m_awaddr;
    logic [2:0]  m_awprot;
    logic        m_awvalid;
    logic        m_awready;

    // Write data channel
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;

    // Write response channel
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;

    // Read address channel
    logic [31:0] m_araddr;
    logic [2:0]  m_arprot;
    logic        m_arvalid;
    logic        m_arready;

    // Read data channel
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;

    modport master (
        output m_awaddr, m_awprot, m_awvalid,
        input  m_awready,
        output m_wdata, m_wstrb, m_wvalid,
        input  m_wready,
        input  m_bresp, m_bvalid,
        output m_bready,
        output m_araddr, m_arprot, m_arvalid,
        input  m_arready,
        input  m_rdata, m_rresp, m_rvalid,
        output m_rready
    );

    modport slave (
        input  m_awaddr, m_awprot, m_awvalid,
        output m_awready,
        input  m_wdata, m_wstrb, m_wvalid,
        output m_wready,
        output m_bresp, m_bvalid,
        input  m_bready,
        input  m_araddr, m_arprot, m_arvalid,
        output m_arready,
        output m_rdata, m_rresp, m_rvalid,
        input  m_rready
    );

endinterface

// File: rtl/mem_axi_lite_master.sv
// Memory-stage to AXI4-Lite bridge. Takes one load/store request from the
// pipeline, freezes the pipeline while the bus transaction runs, and spends
// exactly one DONE cycle with the stall released before accepting the next one.
module mem_axi_lite_master (
    input  logic                         clk,
    input  logic                         rst,          // async, active-low

    // Pipeline MEM-stage side
    input  logic                         mem_ce_i,
    input  logic                         mem_we_i,
    input  logic [3:0]                   mem_sel_i,
    input  logic [31:0]                  mem_addr_i,
    input  logic [31:0]                  mem_write_data_i,
    output logic [31:0]                  mem_read_data_o,
    output logic                         stall_req_o,
    output logic                         bus_err_o,

    // AXI4-Lite master side
    mem_axi_lite_master_if.master        axi
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5
    } state_e;

    state_e      state_q,  state_d;
    logic [31:0] addr_q,   addr_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [3:0]  wstrb_q,  wstrb_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q,  w_done_d;
    logic [31:0] rdata_q,  rdata_d;
    logic        err_q,    err_d;

    // Channel acceptance, counting earlier-cycle acceptance via the done flags
    logic aw_hs, w_hs, aw_ok, w_ok;

    // Valids and readys decode from registered state only, never from a ready
    assign axi.m_awvalid = (state_q == WR_REQ) && !aw_done_q;
    assign axi.m_wvalid  = (state_q == WR_REQ) && !w_done_q;
    assign axi.m_bready  = (state_q == WR_RESP);
    assign axi.m_arvalid = (state_q == RD_ADDR);
    assign axi.m_rready  = (state_q == RD_DATA);

    assign axi.m_awaddr  = addr_q;
    assign axi.m_araddr  = addr_q;
    assign axi.m_wdata   = wdata_q;
    assign axi.m_wstrb   = wstrb_q;
    assign axi.m_awprot  = 3'b000;
    assign axi.m_arprot  = 3'b000;

    assign aw_hs = axi.m_awvalid && axi.m_awready;
    assign w_hs  = axi.m_wvalid  && axi.m_wready;
    assign aw_ok = aw_done_q || aw_hs;
    assign w_ok  = w_done_q  || w_hs;

    // The pipeline may advance only in DONE, where the result is available
    assign stall_req_o     = mem_ce_i && (state_q != DONE);
    assign mem_read_data_o = rdata_q;
    assign bus_err_o       = err_q;

    // Next-state and datapath-capture logic
    always_comb begin
        // NOTE: every _d signal gets its hold value first so no latch can be inferred.
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_ce_i) begin
                    addr_d    = mem_addr_i & 32'hFFFF_FFFC;  // word-aligned
                    wdata_d   = mem_write_data_i;
                    wstrb_d   = mem_sel_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = mem_we_i ? WR_REQ : RD_ADDR;
                end
            end

            WR_REQ: begin
                if (aw_ok && w_ok) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_RESP;
                end else begin
                    aw_done_d = aw_ok;
                    w_done_d  = w_ok;
                end
            end

            WR_RESP: begin
                if (axi.m_bvalid) begin
                    err_d   = (axi.m_bresp != 2'b00);
                    state_d = DONE;
                end
            end

            RD_ADDR: begin
                if (axi.m_arready) begin
                    state_d = RD_DATA;
                end
            end

            RD_DATA: begin
                if (axi.m_rvalid) begin
                    rdata_d = axi.m_rdata;
                    err_d   = (axi.m_rresp != 2'b00);
                    state_d = DONE;
                end
            end

            DONE:    state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: address/data/strobe registers are cleared too, so the bus
            // never shows stale values from an abandoned transaction.
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_axi_lite_master.sv
// Directed bench for mem_axi_lite_master: the slave side is driven cycle by
// cycle, and expected completion results sit in a scoreboard queue until the
// DONE cycle in which the bridge releases the stall.
module tb_mem_axi_lite_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_write_data_i;
    logic [31:0] mem_read_data_o;
    logic        stall_req_o;
    logic        bus_err_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];

    mem_axi_lite_master_if axi ();

    mem_axi_lite_master dut (
        .clk              (clk),
        .rst              (rst),
        .mem_ce_i         (mem_ce_i),
        .mem_we_i         (mem_we_i),
        .mem_sel_i        (mem_sel_i),
        .mem_addr_i       (mem_addr_i),
        .mem_write_data_i (mem_write_data_i),
        .mem_read_data_o  (mem_read_data_o),
        .stall_req_o      (stall_req_o),
        .bus_err_o        (bus_err_o),
        .axi              (axi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, req);
        end
    endtask

    // Move to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic slave_quiet();
        axi.m_awready = 1'b0;
        axi.m_wready  = 1'b0;
        axi.m_bvalid  = 1'b0;
        axi.m_bresp   = 2'b00;
        axi.m_arready = 1'b0;
        axi.m_rvalid  = 1'b0;
        axi.m_rdata   = 32'h0;
        axi.m_rresp   = 2'b00;
    endtask

    task automatic mem_req(input logic we, input logic [3:0] sel,
                           input logic [31:0] addr, input logic [31:0] wd);
        mem_ce_i         = 1'b1;
        mem_we_i         = we;
        mem_sel_i        = sel;
        mem_addr_i       = addr;
        mem_write_data_i = wd;
        #1;
    endtask

    // Called in the cycle expected to be DONE: compare against the oldest entry
    task automatic finish_txn(input string tag);
        exp_t e;
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_rdata"}, mem_read_data_o, e.rdata);
            check({tag, "_err"},   32'(bus_err_o),  32'(e.err));
        end
        check({tag, "_stall_done"}, 32'(stall_req_o), 32'd0);
    endtask

    function automatic logic [4:0] all_vr();
        return {axi.m_awvalid, axi.m_wvalid, axi.m_arvalid, axi.m_bready, axi.m_rready};
    endfunction

    initial begin
        rst = 1'b1;
        mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = 4'h0;
        mem_addr_i = 32'h0; mem_write_data_i = 32'h0;
        slave_quiet();

        // ---- reset state
        #1 rst = 1'b0;
        #2;
        check("rst_vr",     32'(all_vr()),       32'd0);
        check("rst_rdata",  mem_read_data_o,     32'h0);
        check("rst_err",    32'(bus_err_o),      32'd0);
        check("rst_stall",  32'(stall_req_o),    32'd0);
        check("rst_awaddr", axi.m_awaddr,        32'h0);
        check("rst_wstrb",  32'(axi.m_wstrb),    32'd0);
        #9 rst = 1'b1;

        // ---- no request for 10 cycles
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_vr",    32'(all_vr()),    32'd0);
            check("idle_stall", 32'(stall_req_o), 32'd0);
        end

        // ---- read, zero-wait slave (arready raised before arvalid)
        step();
        axi.m_arready = 1'b1;
        mem_req(1'b0, 4'hF, 32'h0000_1006, 32'h0);
        sb.push_back('{rdata: 32'hA1B2C3D4, err: 1'b0});
        check("rd0_c0_stall",   32'(stall_req_o),   32'd1);
        check("rd0_c0_arvalid", 32'(axi.m_arvalid), 32'd0);
        step();
        check("rd0_c1_arvalid", 32'(axi.m_arvalid), 32'd1);
        check("rd0_c1_araddr",  axi.m_araddr,       32'h0000_1004);
        check("rd0_c1_arprot",  32'(axi.m_arprot),  32'd0);
        check("rd0_c1_stall",   32'(stall_req_o),   32'd1);
        step();
        axi.m_arready = 1'b0;
        axi.m_rvalid  = 1'b1;
        axi.m_rdata   = 32'hA1B2C3D4;
        #1;
        check("rd0_c2_rready",  32'(axi.m_rready),  32'd1);
        check("rd0_c2_arvalid", 32'(axi.m_arvalid), 32'd0);
        check("rd0_c2_stall",   32'(stall_req_o),   32'd1);
        step();
        slave_quiet();
        finish_txn("rd0");
        check("rd0_c3_rready",  32'(axi.m_rready),  32'd0);
        mem_ce_i = 1'b0;
        step();
        check("rd0_c4_vr",      32'(all_vr()),      32'd0);

        // ---- write, awready two cycles late, wready immediate
        step();
        axi.m_wready = 1'b1;
        mem_req(1'b1, 4'b0010, 32'h0000_2002, 32'h0000_5500);
        sb.push_back('{rdata: 32'hA1B2C3D4, err: 1'b0});
        check("wr0_c0_vr",      32'(all_vr()),      32'd0);
        check("wr0_c0_stall",   32'(stall_req_o),   32'd1);
        step();
        check("wr0_c1_awvalid", 32'(axi.m_awvalid), 32'd1);
        check("wr0_c1_wvalid",  32'(axi.m_wvalid),  32'd1);
        check("wr0_c1_awaddr",  axi.m_awaddr,       32'h0000_2000);
        check("wr0_c1_wdata",   axi.m_wdata,        32'h0000_5500);
        check("wr0_c1_wstrb",   32'(axi.m_wstrb),   32'b0010);
        check("wr0_c1_awprot",  32'(axi.m_awprot),  32'd0);
        step();
        axi.m_wready = 1'b0;
        check("wr0_c2_wvalid",  32'(axi.m_wvalid),  32'd0);
        check("wr0_c2_awvalid", 32'(axi.m_awvalid), 32'd1);
        check("wr0_c2_stall",   32'(stall_req_o),   32'd1);
        step();
        axi.m_awready = 1'b1;
        check("wr0_c3_awvalid", 32'(axi.m_awvalid), 32'd1);
        check("wr0_c3_wvalid",  32'(axi.m_wvalid),  32'd0);
        check("wr0_c3_bready",  32'(axi.m_bready),  32'd0);
        step();
        axi.m_awready = 1'b0;
        axi.m_bvalid  = 1'b1;
        axi.m_bresp   = 2'b00;
        check("wr0_c4_bready",  32'(axi.m_bready),  32'd1);
        check("wr0_c4_awvalid", 32'(axi.m_awvalid), 32'd0);
        step();
        slave_quiet();
        finish_txn("wr0");
        check("wr0_c5_bready",  32'(axi.m_bready),  32'd0);
        mem_ce_i = 1'b0;
        step();
        check("wr0_c6_vr",      32'(all_vr()),      32'd0);
        check("wr0_c6_stall",   32'(stall_req_o),   32'd0);

        // ---- read with SLVERR, arready and rvalid each one cycle late
        step();
        mem_req(1'b0, 4'hF, 32'h0000_0100, 32'h0);
        sb.push_back('{rdata: 32'hDEADBEEF, err: 1'b1});
        step();
        check("rd1_c1_arvalid", 32'(axi.m_arvalid), 32'd1);
        step();
        check("rd1_c2_arhold",  32'(axi.m_arvalid), 32'd1);
        axi.m_arready = 1'b1;
        step();
        axi.m_arready = 1'b0;
        check("rd1_c3_rready",  32'(axi.m_rready),  32'd1);
        step();
        axi.m_rvalid = 1'b1;
        axi.m_rdata  = 32'hDEADBEEF;
        axi.m_rresp  = 2'b10;
        check("rd1_c4_rready",  32'(axi.m_rready),  32'd1);
        check("rd1_c4_err",     32'(bus_err_o),     32'd0);
        step();
        slave_quiet();
        finish_txn("rd1");
        mem_ce_i = 1'b0;
        step();
        check("rd1_c6_err",     32'(bus_err_o),     32'd0);
        check("rd1_c6_rdata",   mem_read_data_o,    32'hDEADBEEF);

        // ---- back-to-back: write (DECERR, same-cycle aw/w accept) then read
        step();
        axi.m_awready = 1'b1;
        axi.m_wready  = 1'b1;
        mem_req(1'b1, 4'hF, 32'h0000_3000, 32'h1234_5678);
        sb.push_back('{rdata: 32'hDEADBEEF, err: 1'b1});
        step();
        check("b2b_c1_awvalid", 32'(axi.m_awvalid), 32'd1);
        check("b2b_c1_wvalid",  32'(axi.m_wvalid),  32'd1);
        step();
        slave_quiet();
        axi.m_bvalid = 1'b1;
        axi.m_bresp  = 2'b11;
        check("b2b_c2_bready",  32'(axi.m_bready),  32'd1);
        check("b2b_c2_wvalid",  32'(axi.m_wvalid),  32'd0);
        step();
        slave_quiet();
        finish_txn("b2b_wr");
        mem_req(1'b0, 4'hF, 32'h0000_4008, 32'h0);
        sb.push_back('{rdata: 32'h0BAD_F00D, err: 1'b0});
        step();
        axi.m_arready = 1'b1;
        check("b2b_c4_stall",   32'(stall_req_o),   32'd1);
        check("b2b_c4_vr",      32'(all_vr()),      32'd0);
        check("b2b_c4_err",     32'(bus_err_o),     32'd0);
        step();
        check("b2b_c5_arvalid", 32'(axi.m_arvalid), 32'd1);
        check("b2b_c5_araddr",  axi.m_araddr,       32'h0000_4008);
        check("b2b_c5_awvalid", 32'(axi.m_awvalid), 32'd0);
        step();
        axi.m_arready = 1'b0;
        axi.m_rvalid  = 1'b1;
        axi.m_rdata   = 32'h0BAD_F00D;
        check("b2b_c6_rready",  32'(axi.m_rready),  32'd1);
        step();
        slave_quiet();
        finish_txn("b2b_rd");
        mem_ce_i = 1'b0;

        // ---- reset asserted while in RD_DATA
        step();
        axi.m_arready = 1'b1;
        mem_req(1'b0, 4'hF, 32'h0000_5000, 32'h0);
        step();
        step();
        axi.m_arready = 1'b0;
        check("rst_mid_rready_pre", 32'(axi.m_rready), 32'd1);
        #2;
        rst      = 1'b0;
        mem_ce_i = 1'b0;
        #1;
        check("rst_mid_vr",     32'(all_vr()),      32'd0);
        check("rst_mid_rdata",  mem_read_data_o,    32'h0);
        check("rst_mid_err",    32'(bus_err_o),     32'd0);
        check("rst_mid_stall",  32'(stall_req_o),   32'd0);
        check("rst_mid_araddr", axi.m_araddr,       32'h0);
        #3 rst = 1'b1;

        // ---- first request after reset starts cleanly from IDLE
        step();
        axi.m_arready = 1'b1;
        mem_req(1'b0, 4'hF, 32'h0000_6000, 32'h0);
        sb.push_back('{rdata: 32'h1111_2222, err: 1'b0});
        check("post_c0_arvalid", 32'(axi.m_arvalid), 32'd0);
        step();
        check("post_c1_arvalid", 32'(axi.m_arvalid), 32'd1);
        check("post_c1_araddr",  axi.m_araddr,       32'h0000_6000);
        step();
        axi.m_arready = 1'b0;
        axi.m_rvalid  = 1'b1;
        axi.m_rdata   = 32'h1111_2222;
        step();
        slave_quiet();
        finish_txn("post");
        mem_ce_i = 1'b0;
        step();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_axi_lite_master.md
MEM_AXI_LITE_MASTER -- requirements
Module: mem_axi_lite_master

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 SHALL provide ports: clk input 1 system clock; rst input 1 async active-low reset.
REQ-003 SHALL provide MEM-side ports: mem_ce_i input 1 access request; mem_we_i input 1 write=1/read=0; mem_sel_i input 4 byte lanes, bit3=data[31:24]; mem_addr_i input 32 byte address; mem_write_data_i input 32 lane-positioned store data.
REQ-004 SHALL provide pipeline ports: mem_read_data_o output 32 load data; stall_req_o output 1 freeze request to pipeline control; bus_err_o output 1 one-cycle error pulse.
REQ-005 SHALL provide write-address ports: m_awaddr output 32; m_awprot output 3; m_awvalid output 1; m_awready input 1.
REQ-006 SHALL provide write-data ports: m_wdata output 32; m_wstrb output 4; m_wvalid output 1; m_wready input 1.
REQ-007 SHALL provide write-response ports: m_bresp input 2; m_bvalid input 1; m_bready output 1.
REQ-008 SHALL provide read-address ports: m_araddr output 32; m_arprot output 3; m_arvalid output 1; m_arready input 1.
REQ-009 SHALL provide read-data ports: m_rdata input 32; m_rresp input 2; m_rvalid input 1; m_rready output 1.

Function
REQ-010 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA, DONE.
REQ-011 IDLE: mem_ce_i=1 & mem_we_i=1 -> WR_REQ; mem_ce_i=1 & mem_we_i=0 -> RD_ADDR; else stay.
REQ-012 On leaving IDLE SHALL register addr as {mem_addr_i[31:2],2'b00}, wdata=mem_write_data_i, wstrb[i]=mem_sel_i[i]; held stable until DONE.
REQ-013 WR_REQ: m_awvalid and m_wvalid assert together; each drops independently after its own valid&ready cycle (aw_done/w_done flags); -> WR_RESP when both accepted, including same-cycle acceptance.
REQ-014 WR_RESP: m_bready=1; on m_bvalid -> DONE.
REQ-015 RD_ADDR: m_arvalid=1; on m_arready -> RD_DATA.
REQ-016 RD_DATA: m_rready=1; on m_rvalid capture m_rdata into mem_read_data_o -> DONE.
REQ-017 DONE: one cycle, then -> IDLE unconditionally; no new request accepted in DONE.
REQ-018 stall_req_o SHALL be combinational = mem_ce_i & (state != DONE).
REQ-019 Minimum latency with zero-wait slave: request seen cycle 0, stall cycles 0-2, DONE cycle 3 with stall_req_o=0.
REQ-020 valid SHALL never drop before handshake; no valid SHALL depend combinationally on any ready.
REQ-021 m_awprot=m_arprot=3'b000 always.
REQ-022 bus_err_o SHALL pulse one cycle (in DONE) if captured bresp/rresp != 2'b00; read data still returned.
REQ-023 mem_read_data_o SHALL hold last captured value until next read completes; writes do not alter it.
REQ-024 Slave ready asserted before valid SHALL not cause acceptance; only valid&ready counts.

Reset
REQ-025 rst=0 SHALL asynchronously force state IDLE, all m_*valid/ready=0, flags clear, mem_read_data_o=0, bus_err_o=0, stored addr/data/strb=0.
REQ-026 Reset mid-transaction SHALL abandon it; after release first request restarts from IDLE.
REQ-027 Reset release SHALL take effect at next rising clk edge.

Verification
REQ-028 Read, zero-wait slave, addr 0x0000_1006, rdata 0xA1B2C3D4 -> m_araddr=0x0000_1004, stall cycles 0-2, cycle 3 mem_read_data_o=0xA1B2C3D4, stall_req_o=0.
REQ-029 Write sel=4'b0010 data 0x0000_5500 addr 0x0000_2002, awready 2 cycles late, wready immediate -> m_wvalid drops after cycle 1, m_awvalid held until accept, m_wstrb=4'b0010, one bready handshake, DONE once.
REQ-030 Read with rresp=2'b10 -> bus_err_o=1 exactly one cycle in DONE, data captured.
REQ-031 Back-to-back write then read (mem_ce_i held) -> DONE cycle between, second transaction starts next IDLE, no duplicate first transaction.
REQ-032 rst=0 asserted while in RD_DATA -> m_rready, m_arvalid, stall_req_o logic state cleared immediately, mem_read_data_o=0.
REQ-033 mem_ce_i=0 for 10 cycles -> no valid asserted, stall_req_o=0.
